// File: rtl/serial_ha_pkg.sv
// Shared types and sizing helpers for the bit-serial half-adder based adder.
// State encoding, default operand width and bit-counter width.
package serial_ha_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must hold 0..WIDTH-1; keep at least one bit for degenerate widths.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_ha_adder_ha_cell.sv
// One-bit half adder: combinational, zero latency, no flow control.
// Two of these form the full-adder slice used each serial step.
module ha_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_ha_adder.sv
// LSB-first bit-serial adder (optional subtract via SERIAL_HA_ADDER_SUB_EN); done pulses WIDTH cycles after start.
// ena=0 stalls every register, so done stretches and start is held off; start is ignored while busy.
module serial_ha_adder
  import serial_ha_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
`ifdef SERIAL_HA_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             sub_en;
  logic [WIDTH-1:0] b_cap;
  logic             ha1_s, ha1_c, bit_s, ha2_c, carry_nxt;

`ifdef SERIAL_HA_ADDER_SUB_EN
  assign sub_en = sub;
`else
  assign sub_en = 1'b0;
`endif

  // Subtraction is a + ~b + 1: invert B on capture and seed the carry.
  assign b_cap = sub_en ? ~b : b;

  ha_cell u_ha1 (.x(a_sr_q[0]), .y(b_sr_q[0]), .s(ha1_s), .c(ha1_c));
  ha_cell u_ha2 (.x(ha1_s),     .y(carry_q),   .s(bit_s), .c(ha2_c));
  assign carry_nxt = ha1_c | ha2_c;

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    if (ena) begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sr_d  = a;
            b_sr_d  = b_cap;
            res_d   = '0;
            carry_d = sub_en;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          a_sr_d  = a_sr_q >> 1;
          b_sr_d  = b_sr_q >> 1;
          res_d   = {bit_s, res_q[WIDTH-1:1]};
          carry_d = carry_nxt;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            // Only publish the completed word; partial sums stay internal.
            sum_d   = {bit_s, res_q[WIDTH-1:1]};
            cout_d  = carry_nxt;
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_ha_adder.sv
// Self-checking bench for serial_ha_adder: vector table, hand sequences, random ops vs arithmetic model.
module tb_serial_ha_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, ena, start, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] es;
    logic       ec;
  } vec_t;

  vec_t vecs[$];

  serial_ha_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .start(start),
`ifdef SERIAL_HA_ADDER_SUB_EN
    .sub  (sub),
`endif
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on the operands.
  task automatic model(input logic [7:0] ta, input logic [7:0] tb2, input logic ts,
                       output logic [7:0] es, output logic ec);
    int r;
    if (ts) begin
      r  = int'(ta) - int'(tb2);
      es = r[7:0];
      ec = (ta >= tb2);
    end else begin
      r  = int'(ta) + int'(tb2);
      es = r[7:0];
      ec = r[8];
    end
  endtask

  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb2, input logic ts);
    @(negedge clk);
    a = ta; b = tb2; sub = ts; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges (after the accepting edge) until done is seen.
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) break;
      if (busy) bc++;
      lat++;
    end
    if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic run_check(input vec_t v, input string tag);
    int lat, bc;
    logic [7:0] held;
    start_op(v.a, v.b, v.sub);
    wait_done(lat, bc);
    chk({tag, "_sum"},  {24'd0, sum}, {24'd0, v.es});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, v.ec});
    chk({tag, "_lat"},  lat, W);
    chk({tag, "_busy"}, bc, W);
    held = sum;
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_hold"}, {24'd0, sum}, {24'd0, held});
  endtask

  initial begin
    int lat, bc;
    logic [7:0] es, prev;
    logic ec, ts;
    vec_t v;

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum",  {24'd0, sum},  32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{a: 8'h5A, b: 8'h3C, sub: 1'b0, es: 8'h96, ec: 1'b0});
    vecs.push_back('{a: 8'hFF, b: 8'h01, sub: 1'b0, es: 8'h00, ec: 1'b1});
    vecs.push_back('{a: 8'h00, b: 8'h00, sub: 1'b0, es: 8'h00, ec: 1'b0});
    vecs.push_back('{a: 8'h12, b: 8'h34, sub: 1'b0, es: 8'h46, ec: 1'b0});
    vecs.push_back('{a: 8'hFF, b: 8'hFF, sub: 1'b0, es: 8'hFE, ec: 1'b1});
`ifdef SERIAL_HA_ADDER_SUB_EN
    vecs.push_back('{a: 8'h10, b: 8'h01, sub: 1'b1, es: 8'h0F, ec: 1'b1});
    vecs.push_back('{a: 8'h01, b: 8'h02, sub: 1'b1, es: 8'hFF, ec: 1'b0});
`endif
    foreach (vecs[i]) run_check(vecs[i], $sformatf("vec%0d", i));

    // Stall for 3 cycles in the middle of RUN.
    prev = sum;
    start_op(8'h12, 8'h34, 1'b0);
    repeat (4) @(negedge clk);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_busy", {31'd0, busy}, 32'd1);
      chk("stall_done", {31'd0, done}, 32'd0);
      chk("stall_sum",  {24'd0, sum},  {24'd0, prev});
    end
    ena = 1'b1;
    wait_done(lat, bc);
    chk("stall_lat", lat + 7, W + 3);
    chk("stall_res", {24'd0, sum}, 32'h46);
    // done stretches while stalled
    ena = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("stretch_done", {31'd0, done}, 32'd1);
    end
    ena = 1'b1;
    @(negedge clk);
    chk("stretch_release", {31'd0, done}, 32'd0);

    // start during RUN is ignored; start held in DONE chains without a bubble.
    start_op(8'h22, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00;
    wait_done(lat, bc);
    chk("ignore_sum",  {24'd0, sum}, 32'h33);
    chk("ignore_cout", {31'd0, cout}, 32'd0);
    a = 8'h01; b = 8'h02; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_done", {31'd0, done}, 32'd0);
    wait_done(lat, bc);
    chk("b2b_lat", lat, W - 1);
    chk("b2b_sum", {24'd0, sum}, 32'h03);

    // Asynchronous reset mid-RUN.
    start_op(8'hAB, 8'hCD, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_sum",  {24'd0, sum},  32'd0);
    chk("arst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_check('{a: 8'h40, b: 8'h41, sub: 1'b0, es: 8'h81, ec: 1'b0}, "post_rst");

    // Random operations against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
`ifdef SERIAL_HA_ADDER_SUB_EN
      ts = 1'($urandom_range(0, 1));
`else
      ts = 1'b0;
`endif
      v.a   = 8'($urandom_range(0, 255));
      v.b   = 8'($urandom_range(0, 255));
      v.sub = ts;
      model(v.a, v.b, v.sub, es, ec);
      v.es = es;
      v.ec = ec;
      run_check(v, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
